// File: rtl/shifter_seq.sv
// shifter_seq: multi-cycle barrel shifter that applies one log2 stage per clock.
// Supports SLL, SRL and SRA. Op 11 is rotate-right when SHIFTER_ROTATE_EN is
// defined; otherwise op 11 decodes as SRL and no rotate logic is built.
// Uses a valid/ready handshake on both the operand side and the result side.

module shifter_seq #(
   parameter int WIDTH   = 16,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_zero
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } state_t;

   localparam logic [1:0] OpSll = 2'b00;
   localparam logic [1:0] OpSra = 2'b10;
`ifdef SHIFTER_ROTATE_EN
   localparam logic [1:0] OpRor = 2'b11;
`endif

   localparam logic [WIDTH-1:0]   AllOnes   = '1;
   localparam logic [SHAMT_W-1:0] LastStage = SHAMT_W'(SHAMT_W - 1);

   state_t             r_state;
   logic [WIDTH-1:0]   r_work;
   logic [SHAMT_W-1:0] r_shamt;
   logic [SHAMT_W-1:0] r_stage;
   logic [1:0]         r_op;
   logic               r_sign;
   logic               r_inReady;
   logic               r_outValid;
   logic [WIDTH-1:0]   r_outData;
   logic               r_outZero;

   logic [31:0]        w_amt;
   logic [WIDTH-1:0]   w_shr;
   logic [WIDTH-1:0]   w_shifted;
   logic [WIDTH-1:0]   w_stageOut;

   assign in_ready  = r_inReady;
   assign out_valid = r_outValid;
   assign out_data  = r_outData;
   assign out_zero  = r_outZero;

   // One shift stage: the amount doubles each stage, and the stage is applied only
   // when the lowest remaining shamt bit is set. The shamt register shifts right
   // each stage, so bit 0 always belongs to the current stage. Op 11 falls into
   // the default arm (SRL) unless rotate is built in.
   always_comb begin
      w_amt      = 32'd1 << r_stage;
      w_shr      = r_work >> w_amt;
      w_shifted  = w_shr;
      case (r_op)
         OpSll:   w_shifted = r_work << w_amt;
         OpSra:   w_shifted = w_shr | (r_sign ? ~(AllOnes >> w_amt) : '0);
`ifdef SHIFTER_ROTATE_EN
         OpRor:   w_shifted = w_shr | (r_work << (WIDTH - w_amt));
`endif
         default: w_shifted = w_shr;
      endcase
      w_stageOut = r_shamt[0] ? w_shifted : r_work;
   end

   // Control FSM and datapath registers. Every operation runs all SHAMT_W stages,
   // even when shamt is zero, so latency is fixed. The result is copied to
   // out_data on the last stage and kept after the hand-off. A release from DONE
   // raises in_ready only from the next cycle, so a new operand is never
   // accepted on the same edge that releases the previous result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_work     <= '0;
         r_shamt    <= '0;
         r_stage    <= '0;
         r_op       <= OpSll;
         r_sign     <= 1'b0;
         r_inReady  <= 1'b1;
         r_outValid <= 1'b0;
         r_outData  <= '0;
         r_outZero  <= 1'b1;
      end else begin
         case (r_state)
            StIdle: begin
               if (in_valid) begin
                  r_work    <= in_data;
                  r_shamt   <= in_shamt;
                  r_op      <= in_op;
                  r_sign    <= in_data[WIDTH-1];
                  r_stage   <= '0;
                  r_inReady <= 1'b0;
                  r_state   <= StBusy;
               end
            end
            StBusy: begin
               r_work  <= w_stageOut;
               r_shamt <= r_shamt >> 1;
               r_stage <= r_stage + 1'b1;
               if (r_stage == LastStage) begin
                  r_state    <= StDone;
                  r_outValid <= 1'b1;
                  r_outData  <= w_stageOut;
                  r_outZero  <= (w_stageOut == '0);
               end
            end
            StDone: begin
               if (out_ready) begin
                  r_outValid <= 1'b0;
                  r_inReady  <= 1'b1;
                  r_state    <= StIdle;
               end
            end
            default: begin
               r_state    <= StIdle;
               r_inReady  <= 1'b1;
               r_outValid <= 1'b0;
            end
         endcase
      end
   end

endmodule
